twiddle_stream_gen: RTL
=======================

Name: twiddle_stream_gen

Overview:
- Produces the twiddle-factor stream consumed by the modular multiplier stage of the NTT datapath.
- On a start command it emits the sequence base^0, base^1, ..., base^(count-1) mod MODULUS, one word per accepted transfer, over a valid/ready handshake.
- The controller issues one command per NTT stage, each with the stage root and butterfly count.

Parameters:
- MODULUS, 7681, prime modulus q for all arithmetic.
- DATA_W, 32, width of base and twiddle words; upper bits above 13 are zero on output.
- CNT_W, 16, width of the count field and the index counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle command strobe; sampled only in IDLE.
- base  input  DATA_W  stage root; reduced mod MODULUS on capture.
- count  input  CNT_W  number of twiddles to emit.
- tw_valid  output  1  twiddle_factor is valid.
- tw_ready  input  1  consumer accepts the word this cycle.
- twiddle_factor  output  DATA_W  current power base^k mod MODULUS.
- tw_last  output  1  high with the final word (k = count-1).
- tw_index  output  CNT_W  exponent k of the current word.
- busy  output  1  high in SEED and RUN.
- done  output  1  one-cycle pulse after the last transfer, or on a count = 0 command.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE and all outputs = 0. Internal registers are cleared: base_r = 0, acc = 1, remaining = 0.
- IDLE:
  - start with count != 0: capture base_r = base % MODULUS and remaining = count; set acc = 1 and tw_index = 0; go to SEED.
  - start with count == 0: pulse done next cycle, stay in IDLE, emit nothing.
- SEED (1 cycle): go to RUN and assert tw_valid with twiddle_factor = 1. Start-to-first-valid latency is 2 cycles.
- RUN:
  - tw_valid stays high.
  - On handshake (tw_valid & tw_ready):
    - acc <= (acc * base_r) % MODULUS. Full 64-bit product, reduced in the same cycle.
    - tw_index increments and remaining decrements.
    - If that transfer was the last one: go to IDLE, deassert tw_valid, pulse done.
  - Throughput is one word per cycle while tw_ready is held high.
- Backpressure: while tw_valid & !tw_ready, twiddle_factor, tw_index and tw_last hold stable. No value is skipped or repeated.
- tw_last = (remaining == 1) & tw_valid.
- twiddle_factor is always < MODULUS.
- base_r = 0: sequence is 1, 0, 0, .... base_r = 1: all ones.
- start while busy is ignored; there is no command queue.
- Reset mid-stream aborts immediately: tw_valid drops asynchronously and there is no done pulse.
- count = 2^CNT_W - 1 must complete with no counter wrap. tw_index reaches count-1 at most.

Decomposition:
- Package ntt_pkg holds:
  - MODULUS_Q = 7681;
  - word typedef (32 bits) and product typedef (64 bits);
  - FSM enum {IDLE, SEED, RUN}.
- One sub-module, mod_mul_comb:
  - combinational a*b % MODULUS, ports a, b, p;
  - instantiated for the acc update;
  - reused by later INTT scaling blocks.

Test Plan:
- Reset, then start with base = 3844, count = 4 and tw_ready held high -> words 1, 3844, 5773, 1003 on consecutive cycles. tw_index = 0..3; tw_last on 1003; done pulses one cycle after that transfer.
- base = 7680 (q-1), count = 5 -> 1, 7680, 1, 7680, 1; tw_last on the 5th word.
- Same as the first case, but tw_ready low for 3 cycles while 5773 is presented -> 5773 and tw_index = 2 held stable; sequence continues unchanged.
- base = 7681 + 3844 (unreduced), count = 2 -> 1, 3844.
- count = 0 -> no tw_valid, done pulses once. start asserted during RUN -> ignored, original stream completes.
- Assert rst asynchronously mid-stream after 2 words -> tw_valid and busy go to 0 immediately with no done. A new start with base = 2, count = 3 then yields 1, 2, 4.

Source files
------------

// File: rtl/twiddle_stream_gen_pkg.sv
// Shared NTT datapath types: prime modulus, word/product widths and the
// twiddle generator state encoding.
package ntt_pkg;
  localparam int MODULUS_Q = 7681;

  typedef logic [31:0] word_t;
  typedef logic [63:0] prod_t;

  typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;
endpackage

// File: rtl/twiddle_stream_gen_if.sv
// Twiddle word stream: valid/ready handshake with index and last markers.
interface twiddle_stream_gen_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  logic              tw_valid;
  logic              tw_ready;
  logic [DATA_W-1:0] twiddle_factor;
  logic              tw_last;
  logic [CNT_W-1:0]  tw_index;

  modport master (output tw_valid, twiddle_factor, tw_last, tw_index,
                  input  tw_ready);
  modport slave  (input  tw_valid, twiddle_factor, tw_last, tw_index,
                  output tw_ready);
endinterface

// File: rtl/twiddle_stream_gen_mod_mul_comb.sv
// Combinational modular multiply p = a*b mod MODULUS using the full
// double-width product; shared with the INTT scaling blocks.
module mod_mul_comb #(
  parameter int DATA_W  = 32,
  parameter int MODULUS = ntt_pkg::MODULUS_Q
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] p
);
  logic [2*DATA_W-1:0] w_prod;
  logic [2*DATA_W-1:0] w_rem;

  assign w_prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  assign w_rem  = w_prod % (2*DATA_W)'(MODULUS);
  assign p      = w_rem[DATA_W-1:0];
endmodule

// File: rtl/twiddle_stream_gen.sv
// Emits base^0 .. base^(count-1) mod MODULUS over a valid/ready stream,
// one command per NTT stage.
module twiddle_stream_gen
  import ntt_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 16,
  parameter int MODULUS = MODULUS_Q
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   base,
  input  logic [CNT_W-1:0]    count,
  twiddle_stream_gen_if.master tw,
  output logic                busy,
  output logic                done
);
  state_t            r_state;
  logic [DATA_W-1:0] r_base;
  logic [DATA_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  r_index;
  logic              r_valid;
  logic              r_last;
  logic              r_busy;
  logic              r_done;
  logic [DATA_W-1:0] w_next_acc;
  logic              w_hs;

  function automatic logic [DATA_W-1:0] reduce_mod(input logic [DATA_W-1:0] x);
    return x % DATA_W'(MODULUS);
  endfunction

  mod_mul_comb #(.DATA_W(DATA_W), .MODULUS(MODULUS)) u_mod_mul (
    .a (r_acc),
    .b (r_base),
    .p (w_next_acc)
  );

  assign w_hs = r_valid & tw.tw_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_acc       <= DATA_W'(1);
      r_remaining <= '0;
      r_index     <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              r_base      <= reduce_mod(base);
              r_remaining <= count;
              r_acc       <= DATA_W'(1);
              r_index     <= '0;
              r_busy      <= 1'b1;
              r_state     <= SEED;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        SEED: begin
          r_valid <= 1'b1;
          r_last  <= (r_remaining == CNT_W'(1));
          r_state <= RUN;
        end
        RUN: begin
          if (w_hs) begin
            r_acc       <= w_next_acc;
            r_remaining <= r_remaining - CNT_W'(1);
            if (r_remaining == CNT_W'(1)) begin
              // Index is left at count-1 so it never wraps on a full-range count.
              r_valid <= 1'b0;
              r_last  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_index <= r_index + CNT_W'(1);
              r_last  <= (r_remaining == CNT_W'(2));
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Word is forced to zero outside a transfer so idle/reset outputs read 0.
  assign tw.twiddle_factor = r_valid ? r_acc : '0;
  assign tw.tw_valid       = r_valid;
  assign tw.tw_last        = r_last;
  assign tw.tw_index       = r_index;
  assign busy              = r_busy;
  assign done              = r_done;
endmodule
